// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported backing memory between the
// instruction-fetch port and the data port of the pipeline. The data port
// normally wins contention; a starvation counter hands the next contested
// arbitration to instruction fetch after STARVE_LIM consecutive losses.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_stall_o,

    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_stall_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        SRV_NONE,
        SRV_IF,
        SRV_DM
    } served_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    state_t     state;
    served_t    served;
    logic [3:0] starve_cnt;

    logic arb_phase;
    logic if_cand;
    logic dm_cand;
    logic grant_if;
    logic grant_dm;

    // Candidate selection and grant decision; a port that is in its RESP
    // cycle is excluded so its still-high request is not served twice.
    always_comb begin
        arb_phase = (state == IDLE) || (state == RESP);
        if_cand   = if_req_i && !((state == RESP) && (served == SRV_IF));
        dm_cand   = dm_req_i && !((state == RESP) && (served == SRV_DM));
        grant_if  = arb_phase && if_cand && (!dm_cand || (starve_cnt == LIM));
        grant_dm  = arb_phase && dm_cand && !grant_if;
    end

    // A requester stalls until its own RESP cycle.
    assign if_stall_o = if_cand;
    assign dm_stall_o = dm_cand;

    // Arbitration FSM with registered memory-side outputs and read-data capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            served      <= SRV_NONE;
            starve_cnt  <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (grant_if) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                        starve_cnt  <= '0;
                        state       <= BUSY_IF;
                    end else if (grant_dm) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dm_we_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                        if (if_cand && (starve_cnt != LIM)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                        state       <= BUSY_DM;
                    end else begin
                        mem_req_o   <= 1'b0;
                        state       <= IDLE;
                    end
                end
                BUSY_IF: begin
                    if (mem_ack_i) begin
                        if_rdata_o <= mem_rdata_i;
                        mem_req_o  <= 1'b0;
                        served     <= SRV_IF;
                        state      <= RESP;
                    end
                end
                BUSY_DM: begin
                    if (mem_ack_i) begin
                        if (!mem_we_o) begin
                            dm_rdata_o <= mem_rdata_i;
                        end
                        mem_req_o  <= 1'b0;
                        mem_we_o   <= 1'b0;
                        served     <= SRV_DM;
                        state      <= RESP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural
// backing memory of programmable latency.
module tb_mem_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_stall_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] grantQ[$];
    logic [63:0] ifQ[$];
    logic [63:0] dmQ[$];

    int          memLat   = 1;
    logic        memAuto  = 1'b1;
    int          strayReq = 0;
    logic [31:0] lastDmRead = 32'h0;

    mem_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_stall_o  (if_stall_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_stall_o  (dm_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    // Free-running clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Contents the backing memory returns for a given address.
    function automatic logic [31:0] memModel(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h00A00093;
            32'h20:  return 32'h00000055;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive both request ports at once.
    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] dd);
        if_req_i   = ir;
        if_addr_i  = ia;
        dm_req_i   = dr;
        dm_we_i    = dw;
        dm_addr_i  = da;
        dm_wdata_i = dd;
    endtask

    // Step to the input-drive point just after the next rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic waitIfDone(input int budget);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (if_stall_o && n < budget);
        if (if_stall_o) checkOutput("if_timeout", 1, 0);
    endtask

    task automatic waitDmDone(input int budget);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (dm_stall_o && n < budget);
        if (dm_stall_o) checkOutput("dm_timeout", 1, 0);
    endtask

    // Queue an expected load result and remember it as the held value.
    task automatic expectLoad(input logic [31:0] a);
        dmQ.push_back({32'h0, memModel(a)});
        lastDmRead = memModel(a);
    endtask

    // Behavioural memory: acks memLat cycles into a request, or fires a
    // stray ack on demand regardless of any request.
    initial begin
        int ackCnt = 0;
        int strayDone = 0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        forever begin
            @(posedge clk_i);
            #2;
            mem_ack_i = 1'b0;
            if (strayReq != strayDone) begin
                strayDone   = strayReq;
                mem_ack_i   = 1'b1;
                mem_rdata_i = 32'hBAD0_BAD0;
            end else if (memAuto && mem_req_o) begin
                ackCnt++;
                if (ackCnt >= memLat) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = memModel(mem_addr_o);
                    ackCnt      = 0;
                end
            end
        end
    end

    // Scoreboard monitor: checks each new grant and each completed request
    // against the expectations queued when stimulus was driven.
    initial begin
        logic        prevReq = 1'b0;
        logic [63:0] exp;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (mem_req_o && !prevReq) begin
                    if (grantQ.size() == 0) checkOutput("grant_unexpected", 1, 0);
                    else begin
                        exp = grantQ.pop_front();
                        checkOutput("grant", {31'h0, mem_we_o, mem_addr_o}, exp);
                    end
                end
                if (if_req_i && !if_stall_o) begin
                    if (ifQ.size() == 0) checkOutput("if_unexpected", 1, 0);
                    else begin
                        exp = ifQ.pop_front();
                        checkOutput("if_rdata", {32'h0, if_rdata_o}, exp);
                    end
                end
                if (dm_req_i && !dm_stall_o) begin
                    if (dmQ.size() == 0) checkOutput("dm_unexpected", 1, 0);
                    else begin
                        exp = dmQ.pop_front();
                        checkOutput("dm_rdata", {32'h0, dm_rdata_o}, exp);
                    end
                end
            end
            prevReq = mem_req_o;
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        rst_i = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Reset held for two cycles
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_mem_req",   mem_req_o,   0);
        checkOutput("rst_mem_we",    mem_we_o,    0);
        checkOutput("rst_mem_addr",  mem_addr_o,  0);
        checkOutput("rst_mem_wdata", mem_wdata_o, 0);
        checkOutput("rst_if_rdata",  if_rdata_o,  0);
        checkOutput("rst_dm_rdata",  dm_rdata_o,  0);
        checkOutput("rst_stalls",    {if_stall_o, dm_stall_o}, 0);
        cyc();
        rst_i = 1'b0;

        // Single fetch, one-cycle memory latency
        applyStimulus(1, 32'h10, 0, 0, 0, 0);
        grantQ.push_back({31'h0, 1'b0, 32'h10});
        ifQ.push_back({32'h0, memModel(32'h10)});
        @(negedge clk_i);
        checkOutput("f_c0_stall", if_stall_o, 1);
        checkOutput("f_c0_req",   mem_req_o,  0);
        @(negedge clk_i);
        checkOutput("f_c1_stall", if_stall_o, 1);
        checkOutput("f_c1_req",   mem_req_o,  1);
        @(negedge clk_i);
        checkOutput("f_c2_stall", if_stall_o, 0);
        checkOutput("f_c2_req",   mem_req_o,  0);
        cyc();
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Contention: DM load first, IF granted in DM's RESP
        applyStimulus(1, 32'h30, 1, 0, 32'h20, 0);
        grantQ.push_back({31'h0, 1'b0, 32'h20});
        grantQ.push_back({31'h0, 1'b0, 32'h30});
        expectLoad(32'h20);
        ifQ.push_back({32'h0, memModel(32'h30)});
        waitDmDone(20);
        checkOutput("cont_if_stalled", if_stall_o, 1);
        cyc();
        dm_req_i = 1'b0;
        waitIfDone(20);
        checkOutput("cont_dm_hold", dm_rdata_o, 32'h55);
        cyc();
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Starvation: four DM wins over a requesting IF, IF wins the fifth
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'h100 + 32'(i * 4), 1, 0, 32'h200 + 32'(i * 4), 0);
            grantQ.push_back({31'h0, 1'b0, 32'h200 + 32'(i * 4)});
            expectLoad(32'h200 + 32'(i * 4));
            cyc();
            if_req_i = 1'b0;
            waitDmDone(20);
            cyc();
            dm_req_i = 1'b0;
        end
        applyStimulus(1, 32'h110, 1, 0, 32'h210, 0);
        grantQ.push_back({31'h0, 1'b0, 32'h110});
        grantQ.push_back({31'h0, 1'b0, 32'h210});
        ifQ.push_back({32'h0, memModel(32'h110)});
        expectLoad(32'h210);
        waitIfDone(20);
        checkOutput("starve_dm_waiting", dm_stall_o, 1);
        cyc();
        if_req_i = 1'b0;
        waitDmDone(20);
        cyc();
        dm_req_i = 1'b0;
        // Counter cleared: DM wins the next contest again
        applyStimulus(1, 32'h120, 1, 0, 32'h220, 0);
        grantQ.push_back({31'h0, 1'b0, 32'h220});
        expectLoad(32'h220);
        cyc();
        if_req_i = 1'b0;
        waitDmDone(20);
        cyc();
        dm_req_i = 1'b0;

        // Store with three-cycle memory latency
        memLat = 3;
        applyStimulus(0, 0, 1, 1, 32'h40, 32'hDEADBEEF);
        grantQ.push_back({31'h0, 1'b1, 32'h40});
        dmQ.push_back({32'h0, lastDmRead});
        @(negedge clk_i);
        checkOutput("st_c0_stall", dm_stall_o, 1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            checkOutput("st_busy_req",   mem_req_o,   1);
            checkOutput("st_busy_we",    mem_we_o,    1);
            checkOutput("st_busy_addr",  mem_addr_o,  32'h40);
            checkOutput("st_busy_wdata", mem_wdata_o, 32'hDEADBEEF);
            checkOutput("st_busy_stall", dm_stall_o,  1);
        end
        @(negedge clk_i);
        checkOutput("st_resp_stall", dm_stall_o, 0);
        cyc();
        dm_req_i = 1'b0;
        dm_we_i  = 1'b0;

        // Fetch flushed during BUSY_IF
        memLat = 2;
        applyStimulus(1, 32'h50, 0, 0, 0, 0);
        grantQ.push_back({31'h0, 1'b0, 32'h50});
        cyc();
        if_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("fl_c1_req",   mem_req_o,  1);
        checkOutput("fl_c1_stall", if_stall_o, 0);
        @(negedge clk_i);
        checkOutput("fl_c2_req",   mem_req_o,  1);
        checkOutput("fl_c2_addr",  mem_addr_o, 32'h50);
        @(negedge clk_i);
        checkOutput("fl_resp_req",   mem_req_o,  0);
        checkOutput("fl_resp_rdata", if_rdata_o, memModel(32'h50));
        @(negedge clk_i);
        checkOutput("fl_idle_req",   mem_req_o,  0);
        checkOutput("fl_idle_stall", if_stall_o, 0);
        cyc();

        // Reset during BUSY_DM followed by a stray ack
        memAuto = 1'b0;
        applyStimulus(0, 0, 1, 0, 32'h60, 0);
        grantQ.push_back({31'h0, 1'b0, 32'h60});
        cyc();
        @(negedge clk_i);
        checkOutput("rm_busy_req", mem_req_o, 1);
        cyc();
        rst_i    = 1'b1;
        dm_req_i = 1'b0;
        cyc();
        rst_i = 1'b0;
        strayReq++;
        @(negedge clk_i);
        checkOutput("rm_req",      mem_req_o,  0);
        checkOutput("rm_addr",     mem_addr_o, 0);
        checkOutput("rm_dm_rdata", dm_rdata_o, 0);
        checkOutput("rm_if_rdata", if_rdata_o, 0);
        @(negedge clk_i);
        checkOutput("rm_stray_req",   mem_req_o,  0);
        checkOutput("rm_stray_rdata", dm_rdata_o, 0);
        checkOutput("rm_stray_stall", dm_stall_o, 0);
        memAuto    = 1'b1;
        lastDmRead = 32'h0;
        cyc();

        // Normal load after recovery
        memLat = 1;
        applyStimulus(0, 0, 1, 0, 32'h70, 0);
        grantQ.push_back({31'h0, 1'b0, 32'h70});
        expectLoad(32'h70);
        waitDmDone(20);
        cyc();
        dm_req_i = 1'b0;
        repeat (3) @(negedge clk_i);

        checkOutput("grantQ_empty", grantQ.size(), 0);
        checkOutput("ifQ_empty",    ifQ.size(),    0);
        checkOutput("dmQ_empty",    dmQ.size(),    0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
